fir_mac_filter: RTL and testbench

//  Serial multiply-accumulate FIR filter in the FIFO read clock domain. It pops one sample

---
 rtl/fir_mac_filter.sv | 142 ++++++++++++++
 tb/tb_fir_mac_filter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// fir_mac_filter
//   Serial multiply-accumulate FIR filter running in the FIFO read clock
//   domain. One sample is popped per result; a single multiplier walks the
//   TAPS coefficients, then the accumulator is rounded half-up, shifted,
//   saturated and presented on a valid/ready output.
//
// Ports
//   r_clk       clock (FIFO read clock)
//   r_rst_n     synchronous active-low reset
//   fifo_dat    show-ahead FIFO read data, valid while fifo_empty=0
//   fifo_empty  FIFO empty flag
//   fifo_ren    FIFO read enable, pops fifo_dat on the same edge
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   tap index to write
//   coef_dat    coefficient value (signed)
//   o_valid     o_dat holds a result
//   o_ready     sink accepts o_dat on an edge where o_valid&o_ready
//   o_dat       filtered sample (signed)
//   o_sat       o_dat was clipped, qualified by o_valid
//   busy        high whenever a sample is in flight
module fir_mac_filter #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int OUT_SHIFT  = 15,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                       r_clk,
    input  logic                       r_rst_n,
    input  logic [WIDTH-1:0]           fifo_dat,
    input  logic                       fifo_empty,
    output logic                       fifo_ren,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_WIDTH-1:0]      coef_dat,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [OUT_WIDTH-1:0]       o_dat,
    output logic                       o_sat,
    output logic                       busy
);

    localparam int CA_W   = $clog2(TAPS);
    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam int ACC_W  = WIDTH + COEF_WIDTH + CA_W + 1;

    // Rounding and saturation are evaluated one bit wider than the
    // accumulator so the half-LSB addition can never wrap.
    localparam logic signed [ACC_W:0] RND_K    = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [ACC_W:0] SAT_MAX  = {{(ACC_W+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN  = {{(ACC_W+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND,
        HOLD
    } state_t;

    state_t                         state;
    logic signed [WIDTH-1:0]        x [TAPS];
    logic signed [COEF_WIDTH-1:0]   c [TAPS];
    logic signed [ACC_W-1:0]        acc;
    logic [CA_W-1:0]                idx;

    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W:0]          rnd_sum;
    logic signed [ACC_W:0]          r;

    assign fifo_ren = (state == IDLE) && !fifo_empty && r_rst_n;
    assign busy     = (state != IDLE);

    always_comb begin
        prod    = x[idx] * c[idx];
        rnd_sum = $signed({acc[ACC_W-1], acc}) + RND_K;
        r       = rnd_sum >>> OUT_SHIFT;
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
            o_dat   <= '0;
            acc     <= '0;
            idx     <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
        end else begin
            // Gated on IDLE so a sample never mixes old and new coefficients;
            // a write on the pop edge lands before the first MAC cycle.
            if (coef_we && state == IDLE) begin
                c[coef_addr] <= coef_dat;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        for (int unsigned k = 1; k < TAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        x[0]  <= fifo_dat;
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    idx <= idx + CA_W'(1);
                    if (idx == CA_W'(TAPS-1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (r > SAT_MAX) begin
                        o_dat <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
                        o_sat <= 1'b1;
                    end else if (r < SAT_MIN) begin
                        o_dat <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
                        o_sat <= 1'b1;
                    end else begin
                        o_dat <= r[OUT_WIDTH-1:0];
                        o_sat <= 1'b0;
                    end
                    o_valid <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter
//   Directed bench for fir_mac_filter with OUT_SHIFT=2 so that both exact
//   impulse responses (coefficients scaled by 4) and half-up rounding are
//   visible. A small show-ahead FIFO model feeds the DUT and accepted outputs
//   are logged in order for comparison against hand-computed values.
module tb_fir_mac_filter;

    localparam int WIDTH      = 16;
    localparam int COEF_WIDTH = 16;
    localparam int TAPS       = 16;
    localparam int OUT_SHIFT  = 2;
    localparam int OUT_WIDTH  = 16;
    localparam int CA_W       = $clog2(TAPS);

    logic                  r_clk = 1'b0;
    logic                  r_rst_n;
    logic [WIDTH-1:0]      fifo_dat;
    logic                  fifo_empty;
    logic                  fifo_ren;
    logic                  coef_we;
    logic [CA_W-1:0]       coef_addr;
    logic [COEF_WIDTH-1:0] coef_dat;
    logic                  o_valid;
    logic                  o_ready;
    logic [OUT_WIDTH-1:0]  o_dat;
    logic                  o_sat;
    logic                  busy;

    always #5 r_clk = ~r_clk;

    fir_mac_filter #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .TAPS       (TAPS),
        .OUT_SHIFT  (OUT_SHIFT),
        .OUT_WIDTH  (OUT_WIDTH)
    ) dut (
        .r_clk      (r_clk),
        .r_rst_n    (r_rst_n),
        .fifo_dat   (fifo_dat),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_dat   (coef_dat),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_dat      (o_dat),
        .o_sat      (o_sat),
        .busy       (busy)
    );

    // Show-ahead FIFO model
    logic [WIDTH-1:0] fmem [256];
    int unsigned      wr_ptr = 0;
    int unsigned      rd_ptr = 0;
    logic             pop_now = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dat   = fmem[rd_ptr % 256];

    int cyc       = 0;
    int ren_count = 0;
    int ren_bad   = 0;
    int n_out     = 0;
    int out_dat [512];
    int out_sat [512];

    always @(posedge r_clk) begin
        cyc <= cyc + 1;
        if (pop_now) rd_ptr <= rd_ptr + 1;
    end

    // Inputs change just after posedge, so the negedge view is what the
    // next posedge will act on.
    always @(negedge r_clk) begin
        pop_now <= fifo_ren;
        if (fifo_ren) ren_count <= ren_count + 1;
        if (fifo_ren && fifo_empty) ren_bad <= ren_bad + 1;
        if (r_rst_n && o_valid && o_ready) begin
            out_dat[n_out] <= $signed(o_dat);
            out_sat[n_out] <= int'(o_sat);
            n_out          <= n_out + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic push(input int s);
        fmem[wr_ptr % 256] = s[WIDTH-1:0];
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick();
        chk("wait_idle", int'(busy), 0);
    endtask

    task automatic wait_outs(input int target);
        for (int i = 0; i < 3000 && n_out < target; i++) tick();
        chk("output_count", n_out, target);
    endtask

    task automatic write_coef(input int a, input int d);
        wait_idle();
        coef_addr = CA_W'(a);
        coef_dat  = COEF_WIDTH'(d);
        coef_we   = 1'b1;
        tick();
        coef_we   = 1'b0;
    endtask

    typedef struct {
        int sample;
        int exp_dat;
        int exp_sat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t0;
        int t1;
        int viol;
        int rc;
        int held;

        // c0=1, others 0: output = (s + 2) >>> 2
        vecs[0] = '{2, 1, 0};
        vecs[1] = '{-2, 0, 0};
        vecs[2] = '{-3, -1, 0};
        vecs[3] = '{5, 1, 0};
        vecs[4] = '{6, 2, 0};
        vecs[5] = '{7, 2, 0};
        vecs[6] = '{-6, -1, 0};
        vecs[7] = '{-7, -2, 0};
        vecs[8] = '{32767, 8192, 0};
        vecs[9] = '{-32768, -8192, 0};

        r_rst_n   = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_dat  = '0;
        o_ready   = 1'b1;
        tick();
        tick();

        // Reset state, with a sample waiting that must not be popped yet
        push(0);
        tick();
        @(negedge r_clk);
        chk("rst_fifo_ren", int'(fifo_ren), 0);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_sat", int'(o_sat), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_o_dat", $signed(o_dat), 0);
        @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;
        wait_outs(1);
        chk("rst_first_out", out_dat[0], 0);

        // T1 impulse: c[k]=4(k+1) with shift 2 gives k+1
        for (int k = 0; k < TAPS; k++) write_coef(k, 4 * (k + 1));
        base = n_out;
        push(1);
        for (int k = 1; k < TAPS; k++) push(0);
        wait_outs(base + TAPS);
        for (int j = 0; j < TAPS; j++) begin
            chk($sformatf("impulse_dat[%0d]", j), out_dat[base + j], j + 1);
            chk($sformatf("impulse_sat[%0d]", j), out_sat[base + j], 0);
        end

        // Rounding vectors
        write_coef(0, 1);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        base = n_out;
        for (int i = 0; i < 10; i++) push(vecs[i].sample);
        wait_outs(base + 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("round_dat[%0d]", i), out_dat[base + i], vecs[i].exp_dat);
            chk($sformatf("round_sat[%0d]", i), out_sat[base + i], vecs[i].exp_sat);
        end

        // T2 latency, coefficient set still c0=1: 100 -> 25
        wait_idle();
        rc   = ren_count;
        base = n_out;
        viol = 0;
        t0   = -1000;
        push(100);
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            if (fifo_ren) begin
                t0 = cyc;
                break;
            end
        end
        t1 = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge r_clk);
            t1 = cyc;
            if (o_valid) break;
            if (!busy) viol++;
        end
        chk("latency", t1 - t0, TAPS + 2);
        chk("busy_during_op", viol, 0);
        @(posedge r_clk);
        #1;
        wait_outs(base + 1);
        wait_idle();
        chk("latency_ren_pulses", ren_count - rc, 1);
        chk("latency_out", out_dat[base], 25);

        // T3 saturation
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        base = n_out;
        for (int k = 0; k < TAPS; k++) push(32767);
        wait_outs(base + TAPS);
        for (int j = 0; j < TAPS; j++) begin
            chk($sformatf("satmax_dat[%0d]", j), out_dat[base + j], 32767);
            chk($sformatf("satmax_sat[%0d]", j), out_sat[base + j], 1);
        end
        base = n_out;
        for (int k = 0; k < TAPS; k++) push(-32768);
        wait_outs(base + TAPS);
        chk("satmin_dat", out_dat[base + TAPS - 1], -32768);
        chk("satmin_sat", out_sat[base + TAPS - 1], 1);

        // T4 backpressure, c0=4 only: output equals the sample
        write_coef(0, 4);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        wait_idle();
        o_ready = 1'b0;
        base = n_out;
        push(100);
        push(200);
        push(300);
        for (int i = 0; i < 40 && !o_valid; i++) tick();
        chk("bp_valid", int'(o_valid), 1);
        held = $signed(o_dat);
        rc   = ren_count;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge r_clk);
            if ($signed(o_dat) != held || !o_valid || fifo_ren) viol++;
        end
        @(posedge r_clk);
        #1;
        chk("bp_stable", viol, 0);
        chk("bp_no_pop", ren_count - rc, 0);
        chk("bp_held", held, 100);
        o_ready = 1'b1;
        wait_outs(base + 3);
        chk("bp_out0", out_dat[base], 100);
        chk("bp_out1", out_dat[base + 1], 200);
        chk("bp_out2", out_dat[base + 2], 300);

        // T5 empty FIFO stays idle
        wait_idle();
        rc   = ren_count;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            if (busy) viol++;
        end
        @(posedge r_clk);
        #1;
        chk("empty_no_ren", ren_count - rc, 0);
        chk("empty_not_busy", viol, 0);

        // T5 write during MAC is dropped: 10*4 -> 10, not 10*40 -> 100
        base = n_out;
        push(10);
        tick();
        tick();
        tick();
        chk("guard_in_mac", int'(busy), 1);
        coef_addr = '0;
        coef_dat  = COEF_WIDTH'(40);
        coef_we   = 1'b1;
        tick();
        coef_we   = 1'b0;
        wait_outs(base + 1);
        chk("guard_mac_write", out_dat[base], 10);

        // Write and pop on the same IDLE edge: (10*8+2)>>>2 = 20
        wait_idle();
        base      = n_out;
        coef_addr = '0;
        coef_dat  = COEF_WIDTH'(8);
        coef_we   = 1'b1;
        push(10);
        tick();
        coef_we   = 1'b0;
        wait_outs(base + 1);
        chk("guard_idle_write", out_dat[base], 20);

        // T6 reset mid-MAC; x1 holds 10 here so 50*4+10*4 -> 60
        write_coef(0, 4);
        write_coef(1, 4);
        base = n_out;
        push(50);
        wait_outs(base + 1);
        chk("pre_reset_out", out_dat[base], 60);
        wait_idle();
        push(70);
        for (int i = 0; i < 10 && !busy; i++) tick();
        tick();
        tick();
        tick();
        tick();
        r_rst_n = 1'b0;
        tick();
        r_rst_n = 1'b1;
        @(negedge r_clk);
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_dat", $signed(o_dat), 0);
        @(posedge r_clk);
        #1;
        // c0 cleared and x1 cleared: 30 -> 0
        write_coef(1, 4);
        base = n_out;
        push(30);
        wait_outs(base + 1);
        chk("post_rst_cleared", out_dat[base], 0);
        // (25*4 + 30*4 + 2) >>> 2 = 55
        write_coef(0, 4);
        base = n_out;
        push(25);
        wait_outs(base + 1);
        chk("post_rst_new", out_dat[base], 55);

        chk("ren_never_empty", ren_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
